// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                slot_end, frame_end, blink_off;
    logic [DIGITS-1:0]   lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // A load coinciding with the frame edge bypasses pend so no frame mixes two loads.
    always_comb begin : scan_ctrl
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pend_d    = load ? bcd_in : pend_q;
        pend_dp_d = load ? dp_in : pend_dp_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        if (frame_end) begin
            disp_d    = pend_d;
            disp_dp_d = pend_dp_d;
        end
    end

    always_comb begin : lz_detect
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (disp_q[4*i +: 4] == 4'd0);
            lz_blank[i] = blank_lz && zero_above && (i != 0);
        end
    end

    always_comb begin : out_next
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        an_d  = '1;
        if (cnt_q != '0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                    if (!(blink_off && blink_mask[i])) begin
                        seg_d = lz_blank[i] ? 7'b1111111 : decode(disp_q[4*i +: 4]);
                        dp_d  = ~disp_dp_q[i];
                    end
                end
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FR_W-1:0] frame_q, frame_d;
    logic            phase_on_q, phase_on_d;

    always_comb begin : blink_next
        frame_d    = frame_q;
        phase_on_d = phase_on_q;
        if (frame_end) begin
            if (frame_q == FR_W'(BLINK_FRAMES - 1)) begin
                frame_d    = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q    <= '0;
            phase_on_q <= 1'b1;
        end else begin
            frame_q    <= frame_d;
            phase_on_q <= phase_on_d;
        end
    end

    assign blink_off = ~phase_on_q;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            disp_q    <= '0;
            disp_dp_q <= '0;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
`timescale 1ns/1ps
module tb_seg7_scan_driver;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;
    localparam logic [6:0] ENC [16] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9,
                                        SB, SB, SB, SB, SB, SB};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q [$];
    logic [6:0]  g_seg [DIGITS];
    logic [3:0]  g_dp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts {an,seg,dp} produced by each clock edge
    int          m_cnt, m_idx, m_fcnt;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_on;
    always @(posedge clk) begin : model
        logic [11:0] e;
        logic [3:0]  dg;
        logic        off, frame;
        if (!rst_n) begin
            exp_q.push_back({4'hF, 7'h7F, 1'b1});
            m_cnt = 0; m_idx = 0; m_fcnt = 0; m_on = 1'b1;
            m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
        end else begin
            e = {4'hF, 7'h7F, 1'b1};
            if (m_cnt != 0) begin
                dg  = 4'(m_disp >> (4 * m_idx));
                off = BLINK && !m_on && blink_mask[m_idx];
                e[11:8] = ~(4'(1) << m_idx);
                e[7:1]  = (off || (blank_lz && m_idx != 0 && (m_disp >> (4 * m_idx)) == 0))
                          ? SB : ENC[dg];
                e[0]    = off ? 1'b1 : ~m_ddp[m_idx];
            end
            exp_q.push_back(e);
            frame = (m_cnt == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
            if (load) begin
                m_pend = bcd_in;
                m_pdp  = dp_in;
            end
            if (frame) begin
                m_disp = m_pend;
                m_ddp  = m_pdp;
                if (m_fcnt == BLINK_FRAMES - 1) begin
                    m_fcnt = 0;
                    m_on   = !m_on;
                end else begin
                    m_fcnt++;
                end
            end
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("scan", {20'h0, an, seg, dp}, {20'h0, e});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        int n = 0;
        while (an !== target && n < 64) begin
            tick();
            n++;
        end
        check(tag, an, target);
    endtask

    // Align to a frame start (guard followed by digit 0) and record one frame
    task automatic grab_frame();
        logic [3:0] prev = 4'h0;
        int n = 0;
        while (!(prev == 4'hF && an == 4'hE) && n < 64) begin
            prev = an;
            tick();
            n++;
        end
        check("frame_sync", an, 4'hE);
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an[i] == 1'b0) begin
                    g_seg[i] = seg;
                    g_dp[i]  = dp;
                end
            end
            if (k < 14) tick();
        end
    endtask

    task automatic expect_frame(input string tag, input logic [27:0] es, input logic [3:0] ed);
        grab_frame();
        for (int i = 0; i < DIGITS; i++) begin
            check($sformatf("%s_seg%0d", tag, i), g_seg[i], es[7*i +: 7]);
            check($sformatf("%s_dp%0d", tag, i), g_dp[i], ed[i]);
        end
    endtask

    initial begin
        load   = 1'b1;
        bcd_in = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_an", an, 4'hF);
            check("rst_seg", seg, SB);
            check("rst_dp", dp, 1'b1);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        wait_an("first_an", 4'hE);
        check("first_seg", seg, S0);

        do_load(16'h1234, 4'h0);
        grab_frame();
        expect_frame("scan", {S1, S2, S3, S4}, 4'hF);

        wait_an("mid_d1", 4'hD);
        tick();
        do_load(16'h5678, 4'h0);
        wait_an("old_d3", 4'h7);
        check("old_d3_seg", seg, S1);
        expect_frame("fsync", {S5, S6, S7, S8}, 4'hF);
        tick();
        tick();
        do_load(16'h1111, 4'h0);
        tick();
        do_load(16'h2222, 4'h0);
        expect_frame("last_wins", {S2, S2, S2, S2}, 4'hF);

        blank_lz = 1'b1;
        do_load(16'h0070, 4'h0);
        grab_frame();
        expect_frame("lz", {SB, SB, S7, S0}, 4'hF);
        do_load(16'h0000, 4'h0);
        grab_frame();
        expect_frame("lz0", {SB, SB, SB, S0}, 4'hF);

        blank_lz = 1'b0;
        do_load(16'h00A5, 4'b0010);
        grab_frame();
        expect_frame("inv", {S0, S0, SB, S5}, 4'b1101);

`ifdef SEG_BLINK_EN
        blink_mask = 4'b0001;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            grab_frame();
            check($sformatf("blink_d0_f%0d", f), g_seg[0], (f < 2) ? S0 : SB);
            check($sformatf("blink_d1_f%0d", f), g_seg[1], S0);
        end
        wait_an("blink_off_d0", 4'hE);
        check("blink_off_seg", seg, SB);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wait_an("blink_rst_an", 4'hE);
        check("blink_rst_seg", seg, S0);
`endif

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
